counter: RTL and testbench

//   Free-running binary up-counter with wrap-around, cleared by reset.

---
 rtl/counter.sv | 57 +++++
 tb/tb_counter.sv | 102 ++++++++++
 2 files changed

// File: rtl/counter.sv
// Free-running modulo-MODULUS up-counter advancing by STEP per clock.
// Asynchronous active-low reset loads RESET_VALUE; count comes straight from the flop.
module counter #(
    parameter int WIDTH       = 4,
    parameter int MODULUS     = 16,
    parameter int STEP        = 1,
    parameter int RESET_VALUE = 0
) (
    input  logic             clock,
    input  logic             res,
    output logic [WIDTH-1:0] count
);

    // Reject configurations that cannot produce a well-defined sequence.
    if (WIDTH < 1) begin : g_err_width
        $error("counter: WIDTH must be >= 1");
    end
    if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_err_modulus
        $error("counter: MODULUS must lie in 2..2**WIDTH");
    end
    if (STEP < 1 || STEP >= MODULUS) begin : g_err_step
        $error("counter: STEP must lie in 1..MODULUS-1");
    end
    if (RESET_VALUE < 0 || RESET_VALUE >= MODULUS) begin : g_err_reset
        $error("counter: RESET_VALUE must be < MODULUS");
    end

    localparam logic [WIDTH:0]   MOD_W   = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH:0]   STEP_W  = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   wrapped;

    // One extra bit keeps the carry so a single subtract performs the modulo.
    always_comb begin
        sum     = {1'b0, count_q} + STEP_W;
        wrapped = sum - MOD_W;
        count_d = WIDTH'(sum);
        if (sum >= MOD_W) begin
            count_d = WIDTH'(wrapped);
        end
    end

    always_ff @(posedge clock or negedge res) begin
        if (!res) begin
            count_q <= RESET_W;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_counter.sv
// Self-checking bench for counter: a closed-form edge-count model checked every cycle,
// plus directed literal checks for reset, release, wrap and a MODULUS=10/STEP=3 variant.
module tb_counter;

    logic       clk;
    logic       res;
    logic [3:0] count16;
    logic [3:0] count10;

    int errors = 0;
    int checks = 0;

    // Model state: number of counting edges since the last reset.
    int  n_edges = 0;
    bit  model_valid = 0;

    counter #(.WIDTH(4), .MODULUS(16), .STEP(1), .RESET_VALUE(0)) u_dut (
        .clock(clk),
        .res  (res),
        .count(count16)
    );

    counter #(.WIDTH(4), .MODULUS(10), .STEP(3), .RESET_VALUE(0)) u_dut10 (
        .clock(clk),
        .res  (res),
        .count(count10)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%0d expected=%0d", name, $time, got, exp);
        end else begin
            $display("ok   %s t=%0t value=%0d", name, $time, got);
        end
    endtask

    always @(negedge res) begin
        n_edges     = 0;
        model_valid = 1;
    end

    always @(posedge clk) begin
        if (res === 1'b1 && model_valid) n_edges = n_edges + 1;
    end

    // Per-cycle comparison against count = (RESET_VALUE + n*STEP) mod MODULUS.
    always @(negedge clk) begin
        if (model_valid) begin
            check("model_m16", int'(count16), (n_edges * 1) % 16);
            check("model_m10", int'(count10), (n_edges * 3) % 10);
        end
    end

    int seq10 [10] = '{3, 6, 9, 2, 5, 8, 1, 4, 7, 0};

    initial begin
        res = 1'b1;
        #25;  res = 1'b0;                   // t=25, between edges
        #1;   check("async_clear16", int'(count16), 0);
              check("async_clear10", int'(count10), 0);
        #19;  res = 1'b1;                   // t=45
        #6;   check("release_first", int'(count16), 1);   // t=51
        #20;  check("release_second", int'(count16), 2);  // t=71
        #260; check("reach_max", int'(count16), 15);      // t=331
        #20;  check("wrap_zero", int'(count16), 0);       // t=351
        #20;  check("after_wrap", int'(count16), 1);      // t=371
        #120; check("pre_pulse", int'(count16), 7);       // t=491
        #4;   res = 1'b0;                   // t=495
        #1;   check("pulse_clear", int'(count16), 0);     // t=496
        #15;  check("held_at_edge", int'(count16), 0);    // t=511
        #4;   res = 1'b1;                   // t=515
        #16;  check("pulse_release", int'(count16), 1);   // t=531
        #4;   res = 1'b0;                   // t=535
        #16;                                // t=551
        for (int i = 0; i < 5; i++) begin
            check("hold_low16", int'(count16), 0);
            check("hold_low10", int'(count10), 0);
            if (i < 4) #20;
        end
        #14;  res = 1'b1;                   // t=645
        #6;                                 // t=651
        for (int i = 0; i < 10; i++) begin
            check("seq_mod10", int'(count10), seq10[i]);
            if (i < 9) #20;
        end
        #10;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
